spike_readout_acc: RTL
======================

Name: spike_readout_acc

Overview:
- Downstream consumer of the output spike FIFO, which holds 4-bit spike_id entries and uses a fall-through read.
- Drains spike_ids whenever the FIFO is non-empty and keeps one saturating spike count per output class.
- At end of frame, performs a sequential argmax over the class counters and presents the predicted class and its count to the CPU register block.
- Provides a per-class counter read port and sticky error flags.

Parameters:
- ID_W, 4, spike_id width; must match output FIFO WIDTH.
- NUM_CLASSES, 10, number of valid classes; legal range 1..2^ID_W.
- CNT_W, 8, width of each class counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; clears counters and flags, then enters COLLECT.
- frame_end  input  1  one-cycle pulse from SNN controller; no further spikes will be pushed this frame.
- fifo_empty  input  1  output FIFO empty flag.
- fifo_rd_data  input  ID_W  output FIFO head entry; valid when !fifo_empty.
- fifo_pop  output  ID_W=n/a, 1  pop request to output FIFO.
- cnt_rd_idx  input  ID_W  class index for counter readback.
- cnt_rd_data  output  CNT_W  counter[cnt_rd_idx]; registered.
- busy  output  1  high in COLLECT or ARGMAX.
- done  output  1  high in DONE; pred_* are valid.
- pred_class  output  ID_W  argmax class index.
- pred_count  output  CNT_W  count of pred_class.
- invalid_id_err  output  1  sticky; a spike_id >= NUM_CLASSES was popped.
- sat_err  output  1  sticky; an increment was attempted on a saturated counter.

Behaviour:
- Reset, rst_n low at a clk edge (synchronous):
  - state=IDLE.
  - All counters=0, frame_pending=0.
  - Every output=0.
- States: IDLE, COLLECT, ARGMAX, DONE.
- start is honoured in every state and has top priority.
  - Next cycle: state=COLLECT, all counters=0, frame_pending=0, invalid_id_err=0, sat_err=0, pred_class=0, pred_count=0.
  - A frame_end in the same cycle as start is dropped.
  - A pop in the same cycle as start is not performed: fifo_pop=0 in that cycle.
- COLLECT:
  - fifo_pop = !fifo_empty, combinational; the FIFO head is consumed in the same cycle.
  - On each pop with fifo_rd_data < NUM_CLASSES: counter[id] += 1 if below max. At max, hold the value and set sat_err.
  - On each pop with fifo_rd_data >= NUM_CLASSES: discard the entry and set invalid_id_err.
  - frame_end sets frame_pending.
  - Move to ARGMAX when (frame_pending || frame_end) && fifo_empty.
    - If frame_end arrives in cycle N with the FIFO empty, state=ARGMAX at N+1.
    - Otherwise the transition waits until the FIFO has fully drained.
- ARGMAX:
  - fifo_pop=0.
  - Scan index i=0..NUM_CLASSES-1, one class per cycle.
  - Initialise best_idx=0, best_cnt=counter[0].
  - Update only when counter[i] > best_cnt (strict), so the lowest index wins ties.
  - Takes exactly NUM_CLASSES cycles, then DONE.
  - With frame_end in cycle N on an empty FIFO, done=1 first at N+1+NUM_CLASSES.
- DONE:
  - done=1, pred_class=best_idx, pred_count=best_cnt.
  - Held until start or reset.
  - frame_end is ignored. The FIFO is not popped.
- IDLE: fifo_pop=0; frame_end is ignored.
- busy = (state==COLLECT || state==ARGMAX).
- Counters are not cleared on leaving DONE except by start or reset.
- Readback: cnt_rd_data <= counter[cnt_rd_idx] every cycle, in all states.
  - Gives 0 when cnt_rd_idx >= NUM_CLASSES.
  - 1-cycle latency.
  - Reflects the counter value before the same-cycle increment.
- Reset mid-operation: returns to IDLE with all state cleared, regardless of FIFO contents. FIFO contents are not this block's concern.
- Width rules:
  - Counter increment is CNT_W-bit with explicit saturation; no wrap.
  - Argmax index counter width is $clog2(NUM_CLASSES+1).

Test Plan:
1. Basic frame:
   - Stimulus: start; FIFO holds ids 3,3,7,3,1; frame_end while FIFO still non-empty.
   - Response: 5 pops on consecutive cycles; ARGMAX starts the cycle after fifo_empty; done 10 cycles later; pred_class=3, pred_count=3; readback idx7 gives 1.
2. Tie and empty frame:
   - Stimulus: ids 5,2 (one each), then frame_end.
   - Response: pred_class=2, pred_count=1.
   - Stimulus: new start, then frame_end with no spikes.
   - Response: pred_class=0, pred_count=0, done at N+11.
3. Saturation (CNT_W=8):
   - Stimulus: 260 spikes of id 4.
   - Response: counter[4]=255, sat_err=1, pred_class=4, pred_count=255; no wrap to 4.
4. Invalid id:
   - Stimulus: ids 12,15,0.
   - Response: invalid_id_err=1; counter[0]=1; all others 0; 3 pops total.
5. Restart priority:
   - Stimulus: start pulse mid-COLLECT with 4 entries pending in the FIFO, asserted together with frame_end.
   - Response: counters cleared, frame_pending=0, fifo_pop=0 that cycle, state remains COLLECT and resumes popping; no transition to ARGMAX until a later frame_end.
6. Reset and DONE hold:
   - Stimulus: rst_n low during ARGMAX.
   - Response: next cycle all outputs 0, state IDLE; frame_end in IDLE does nothing; fifo_pop stays 0 while the FIFO is non-empty.

Source files
------------

// File: rtl/spike_readout_acc.sv
// Output-spike readout: drains the fall-through spike FIFO into saturating per-class
// counters, then scans them one class per cycle to find the predicted class.
module spike_readout_acc #(
  parameter int ID_W        = 4,
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             frame_end,
  input  logic             fifo_empty,
  input  logic [ID_W-1:0]  fifo_rd_data,
  output logic             fifo_pop,
  input  logic [ID_W-1:0]  cnt_rd_idx,
  output logic [CNT_W-1:0] cnt_rd_data,
  output logic             busy,
  output logic             done,
  output logic [ID_W-1:0]  pred_class,
  output logic [CNT_W-1:0] pred_count,
  output logic             invalid_id_err,
  output logic             sat_err
);

  localparam int               IDX_W    = $clog2(NUM_CLASSES + 1);
  localparam logic [ID_W:0]    NUM_CLS  = (ID_W + 1)'(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_mem [NUM_CLASSES];
  logic             frame_pending;
  logic [IDX_W-1:0] scan_idx;
  logic [ID_W-1:0]  best_idx, best_idx_nxt;
  logic [CNT_W-1:0] best_cnt, best_cnt_nxt;
  logic             id_valid;
  logic             rd_valid;
  logic [CNT_W:0]   inc_res;

  // Returns {saturated, next value}; a saturated counter holds its value.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return {1'b1, v};
    return {1'b0, v + CNT_W'(1)};
  endfunction

  assign id_valid = ({1'b0, fifo_rd_data} < NUM_CLS);
  assign rd_valid = ({1'b0, cnt_rd_idx} < NUM_CLS);
  assign inc_res  = sat_inc(cnt_mem[fifo_rd_data]);
  assign busy     = (state == S_COLLECT) || (state == S_ARGMAX);
  assign done     = (state == S_DONE);

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx_nxt = best_idx;
    best_cnt_nxt = best_cnt;
    if (cnt_mem[scan_idx] > best_cnt) begin
      best_idx_nxt = ID_W'(scan_idx);
      best_cnt_nxt = cnt_mem[scan_idx];
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    if (start) begin
      state_nxt = S_COLLECT;
    end else begin
      case (state)
        S_COLLECT: begin
          fifo_pop = rst_n && !fifo_empty;
          if ((frame_pending || frame_end) && fifo_empty) state_nxt = S_ARGMAX;
        end
        S_ARGMAX: if (scan_idx == LAST_IDX) state_nxt = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_mem[i] <= '0;
      frame_pending  <= 1'b0;
      scan_idx       <= '0;
      best_idx       <= '0;
      best_cnt       <= '0;
      pred_class     <= '0;
      pred_count     <= '0;
      invalid_id_err <= 1'b0;
      sat_err        <= 1'b0;
      cnt_rd_data    <= '0;
    end else begin
      cnt_rd_data <= rd_valid ? cnt_mem[cnt_rd_idx] : '0;
      if (start) begin
        for (int i = 0; i < NUM_CLASSES; i++) cnt_mem[i] <= '0;
        frame_pending  <= 1'b0;
        scan_idx       <= '0;
        best_idx       <= '0;
        best_cnt       <= '0;
        pred_class     <= '0;
        pred_count     <= '0;
        invalid_id_err <= 1'b0;
        sat_err        <= 1'b0;
      end else begin
        case (state)
          S_COLLECT: begin
            if (!fifo_empty) begin
              if (id_valid) begin
                cnt_mem[fifo_rd_data] <= inc_res[CNT_W-1:0];
                if (inc_res[CNT_W]) sat_err <= 1'b1;
              end else begin
                invalid_id_err <= 1'b1;
              end
            end
            if (state_nxt == S_ARGMAX) begin
              frame_pending <= 1'b0;
              scan_idx      <= '0;
              best_idx      <= '0;
              best_cnt      <= '0;
            end else if (frame_end) begin
              frame_pending <= 1'b1;
            end
          end
          S_ARGMAX: begin
            scan_idx <= scan_idx + IDX_W'(1);
            best_idx <= best_idx_nxt;
            best_cnt <= best_cnt_nxt;
            if (scan_idx == LAST_IDX) begin
              pred_class <= best_idx_nxt;
              pred_count <= best_cnt_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
